wash_panel: RTL and testbench
=============================

// Module: wash_panel
// PURPOSE
//   Front-panel controller upstream of the wash countdown/display stage.
//   Debounces the start, program and stop buttons and runs the run/pause/done state machine.
//   Drives the wash stage's 'on' enable, and presents the selected program's preset time
//   as two BCD digits with a one-cycle load strobe.
// PARAMETERS
//   DEB_CYCLES  2_000_000  cycles a synchronised button must hold its new level (20 ms @ 100 MHz)
//   BEEP_CYCLES 50_000_000 length of the done beeper pulse in cycles
//   QUICK_S     8'h30      BCD preset for program 0 (30 s)
//   STD_S       8'h60      BCD preset for program 1 (60 s)
//   HEAVY_S     8'h99      BCD preset for program 2 (99 s)
// PORTS
//   clk          in   1  system clock, 100 MHz
//   rst          in   1  synchronous reset, active-low
//   btn_start    in   1  raw start/pause button, active-high, asynchronous
//   btn_prog     in   1  raw program-select button, active-high, asynchronous
//   btn_stop     in   1  raw stop/cancel button, active-high, asynchronous
//   door_closed  in   1  door switch level, already clean (1 = closed)
//   done         in   1  level from wash stage: countdown has reached 00
//   on           out  1  run enable to wash stage
//   load         out  1  one-cycle strobe: wash stage reloads preset
//   preset_tens  out  4  BCD tens digit of the selected program time
//   preset_ones  out  4  BCD ones digit of the selected program time
//   prog         out  2  selected program, 0..2
//   state        out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE (for status LEDs)
//   beep         out  1  beeper drive
// BEHAVIOUR
//   Reset (rst=0 at posedge clk):
//     state=IDLE, prog=0, preset=QUICK_S; on, load and beep =0.
//     Debouncers cleared to released; their counters are zeroed.
//   Input conditioning:
//     Each button passes through a 2-FF synchroniser, then a debouncer.
//     Debounced level toggles after DEB_CYCLES consecutive cycles at the new synchronised
//     level; any mismatch clears the counter.
//     A press is a 1-cycle pulse on a debounced 0->1 edge. Release generates nothing.
//     Holding a button gives exactly one press.
//   Press-to-action latency: 2 (sync) + DEB_CYCLES cycles, then state updates the next cycle.
//   Priority when events coincide in one cycle: stop > done > door open > start > prog.
//   FSM (registered; on = (state==RUN)):
//     IDLE:
//       prog press -> prog = prog==2 ? 0 : prog+1; preset updates in the same cycle.
//       start press with door_closed=1 -> RUN, with load=1 for that single cycle.
//       start press with door_closed=0 -> ignored, stays IDLE.
//     RUN:
//       stop -> IDLE.
//       done=1 -> DONE.
//       door_closed=0 -> PAUSE.
//       start press -> PAUSE.
//       prog press -> ignored.
//     PAUSE:
//       stop -> IDLE.
//       start press with door_closed=1 -> RUN, no load, so the countdown resumes.
//       prog press -> ignored.
//     DONE:
//       beep=1 for BEEP_CYCLES cycles from entry, then 0.
//       start or stop press -> IDLE, beep forced 0.
//   load is asserted only on the IDLE->RUN transition; never in any other state.
//   preset_* depends only on prog, and is stable whenever load=1.
//   done arriving in IDLE or PAUSE is ignored.
//   A 2-bit state value of 11 is valid only as DONE; no illegal encodings exist.
//   rst low mid-operation returns everything to reset values on the next edge.
//     A button still held across reset does not produce a press until it is released
//     and pressed again.
// TESTING (DEB_CYCLES=4, BEEP_CYCLES=8)
//   1. Reset, then prog pressed 3x (each held 10 cycles) -> prog 1,2,0; preset 60,99,30; state IDLE.
//   2. Door closed, start held 10 cycles -> load high for exactly 1 cycle; state=RUN, on=1.
//      Press-to-RUN latency is 7 cycles.
//   3. Start glitch of 3 cycles -> no press; state unchanged. Held 20 cycles -> exactly one press.
//   4. RUN: door_closed=0 -> PAUSE, on=0, with no load.
//      Door closed again plus start press -> RUN, load stays 0.
//   5. RUN: done=1 and stop press in the same cycle -> IDLE (stop wins), beep stays 0.
//   6. RUN: done=1 -> DONE, beep high for 8 cycles.
//      rst low for 1 cycle during the beep -> IDLE, prog=0, beep=0, on=0.

Source files
------------

// File: rtl/wash_panel_if.sv
// Front-panel bundle between the panel controller and its buttons/wash stage.
// master is the panel side; slave is the button/wash-stage side.
interface wash_panel_if;
    logic       btn_start;
    logic       btn_prog;
    logic       btn_stop;
    logic       door_closed;
    logic       done;
    logic       on;
    logic       load;
    logic [3:0] preset_tens;
    logic [3:0] preset_ones;
    logic [1:0] prog;
    logic [1:0] state;
    logic       beep;

    modport master (
        input  btn_start, btn_prog, btn_stop, door_closed, done,
        output on, load, preset_tens, preset_ones, prog, state, beep
    );

    modport slave (
        output btn_start, btn_prog, btn_stop, door_closed, done,
        input  on, load, preset_tens, preset_ones, prog, state, beep
    );
endinterface

// File: rtl/wash_panel.sv
// Wash front panel: button sync/debounce, program select and
// the idle/run/pause/done controller feeding the countdown stage.
module wash_panel #(
    parameter int          DEB_CYCLES  = 2_000_000,
    parameter int          BEEP_CYCLES = 50_000_000,
    parameter logic [7:0]  QUICK_S     = 8'h30,
    parameter logic [7:0]  STD_S       = 8'h60,
    parameter logic [7:0]  HEAVY_S     = 8'h99
) (
    input  logic          clk,
    input  logic          rst,
    wash_panel_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int BW = $clog2(BEEP_CYCLES + 1);
    localparam logic [CW-1:0] DMAX = CW'(DEB_CYCLES - 1);
    localparam logic [BW-1:0] BMAX = BW'(BEEP_CYCLES - 1);

    logic [2:0]    raw;
    logic [2:0]    s1;
    logic [2:0]    s2;
    logic [2:0]    deb;
    logic [2:0]    deb_d;
    logic [2:0]    blk;
    logic [2:0]    press;
    logic [CW-1:0] cnt [3];
    logic [1:0]    rcnt;
    logic          settled;

    logic          start_p;
    logic          prog_p;
    logic          stop_p;
    logic          door;
    logic [1:0]    prog_nxt;

    state_t        st;
    logic [1:0]    prog_r;
    logic [7:0]    preset;
    logic          on_r;
    logic          load_r;
    logic          beep_r;
    logic [BW-1:0] bcnt;

    assign raw     = {bus.btn_stop, bus.btn_prog, bus.btn_start};
    assign settled = (rcnt == 2'd3);

    // blk masks a button held through reset until it is seen released
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_d <= '0;
            blk   <= '1;
            rcnt  <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_d <= deb;
            if (!settled) begin
                rcnt <= rcnt + 2'd1;
            end
            for (int i = 0; i < 3; i++) begin
                if (s2[i] != deb[i]) begin
                    if (cnt[i] == DMAX) begin
                        deb[i] <= s2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
                if (settled && !s2[i] && !deb[i]) begin
                    blk[i] <= 1'b0;
                end
            end
        end
    end

    assign press   = deb & ~deb_d & ~blk;
    assign start_p = press[0];
    assign prog_p  = press[1];
    assign stop_p  = press[2];
    assign door    = bus.door_closed;

    assign prog_nxt = (prog_r == 2'd2) ? 2'd0 : prog_r + 2'd1;

    function automatic logic [7:0] preset_of(input logic [1:0] p);
        logic [7:0] v;
        v = QUICK_S;
        unique case (1'b1)
            (p == 2'd1): v = STD_S;
            (p == 2'd2): v = HEAVY_S;
            default:     v = QUICK_S;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            st     <= IDLE;
            prog_r <= 2'd0;
            preset <= QUICK_S;
            on_r   <= 1'b0;
            load_r <= 1'b0;
            beep_r <= 1'b0;
            bcnt   <= '0;
        end else begin
            load_r <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (!stop_p && start_p) begin
                        if (door) begin
                            st     <= RUN;
                            on_r   <= 1'b1;
                            load_r <= 1'b1;
                        end
                    end else if (!stop_p && prog_p) begin
                        prog_r <= prog_nxt;
                        preset <= preset_of(prog_nxt);
                    end
                end
                RUN: begin
                    if (stop_p) begin
                        st   <= IDLE;
                        on_r <= 1'b0;
                    end else if (bus.done) begin
                        st     <= DONE;
                        on_r   <= 1'b0;
                        beep_r <= 1'b1;
                        bcnt   <= '0;
                    end else if (!door || start_p) begin
                        st   <= PAUSE;
                        on_r <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (stop_p) begin
                        st <= IDLE;
                    end else if (start_p && door) begin
                        st   <= RUN;
                        on_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (stop_p || start_p) begin
                        st     <= IDLE;
                        beep_r <= 1'b0;
                    end else if (beep_r) begin
                        if (bcnt == BMAX) begin
                            beep_r <= 1'b0;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.on          = on_r;
    assign bus.load        = load_r;
    assign bus.preset_tens = preset[7:4];
    assign bus.preset_ones = preset[3:0];
    assign bus.prog        = prog_r;
    assign bus.state       = st;
    assign bus.beep        = beep_r;

endmodule

// File: tb/tb_wash_panel.sv
// Directed bench for wash_panel with short debounce/beep lengths.
// Inputs change and outputs are sampled on the falling edge.
module tb_wash_panel;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   loads;

    wash_panel_if bus ();

    wash_panel #(
        .DEB_CYCLES  (4),
        .BEEP_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.load === 1'b1) begin
            loads++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       bus.btn_start = v;
            1:       bus.btn_prog  = v;
            default: bus.btn_stop  = v;
        endcase
    endtask

    task automatic hold_btn(input int b, input int n);
        set_btn(b, 1'b1);
        tick(n);
        set_btn(b, 1'b0);
        tick(8);
    endtask

    function automatic logic [7:0] preset();
        return {bus.preset_tens, bus.preset_ones};
    endfunction

    int l0;

    initial begin
        checks = 0;
        errors = 0;
        loads  = 0;
        rst = 1'b0;
        bus.btn_start   = 1'b0;
        bus.btn_prog    = 1'b0;
        bus.btn_stop    = 1'b0;
        bus.door_closed = 1'b0;
        bus.done        = 1'b0;
        tick(2);
        chk("rst_state", 8'(bus.state), 8'd0);
        chk("rst_prog", 8'(bus.prog), 8'd0);
        chk("rst_preset", preset(), 8'h30);
        chk("rst_on", 8'(bus.on), 8'd0);
        chk("rst_load", 8'(bus.load), 8'd0);
        chk("rst_beep", 8'(bus.beep), 8'd0);
        rst = 1'b1;
        tick(5);

        hold_btn(1, 10);
        chk("prog1", 8'(bus.prog), 8'd1);
        chk("preset1", preset(), 8'h60);
        hold_btn(1, 10);
        chk("prog2", 8'(bus.prog), 8'd2);
        chk("preset2", preset(), 8'h99);
        hold_btn(1, 10);
        chk("prog0", 8'(bus.prog), 8'd0);
        chk("preset0", preset(), 8'h30);
        chk("idle_after_prog", 8'(bus.state), 8'd0);

        hold_btn(0, 10);
        chk("start_door_open", 8'(bus.state), 8'd0);

        bus.door_closed = 1'b1;
        l0 = loads;
        bus.btn_start = 1'b1;
        tick(6);
        chk("lat6_idle", 8'(bus.state), 8'd0);
        tick(1);
        chk("lat7_run", 8'(bus.state), 8'd1);
        chk("load_hi", 8'(bus.load), 8'd1);
        chk("on_hi", 8'(bus.on), 8'd1);
        tick(1);
        chk("load_lo", 8'(bus.load), 8'd0);
        tick(2);
        bus.btn_start = 1'b0;
        tick(8);
        chk("load_once", 8'(loads - l0), 8'd1);

        hold_btn(0, 3);
        chk("glitch_run", 8'(bus.state), 8'd1);
        bus.btn_start = 1'b1;
        tick(20);
        chk("hold20_pause", 8'(bus.state), 8'd2);
        bus.btn_start = 1'b0;
        tick(8);
        chk("one_press", 8'(bus.state), 8'd2);
        l0 = loads;
        hold_btn(0, 10);
        chk("resume_run", 8'(bus.state), 8'd1);

        bus.door_closed = 1'b0;
        tick(1);
        chk("door_pause", 8'(bus.state), 8'd2);
        chk("door_on", 8'(bus.on), 8'd0);
        bus.door_closed = 1'b1;
        tick(2);
        chk("door_back", 8'(bus.state), 8'd2);
        hold_btn(1, 10);
        chk("prog_in_pause", 8'(bus.prog), 8'd0);
        hold_btn(0, 10);
        chk("resume2", 8'(bus.state), 8'd1);
        chk("resume_noload", 8'(loads - l0), 8'd0);

        bus.btn_stop = 1'b1;
        tick(6);
        bus.done = 1'b1;
        tick(1);
        chk("stop_wins", 8'(bus.state), 8'd0);
        chk("stop_beep", 8'(bus.beep), 8'd0);
        bus.done = 1'b0;
        tick(3);
        bus.btn_stop = 1'b0;
        tick(8);

        bus.done = 1'b1;
        tick(3);
        chk("done_idle", 8'(bus.state), 8'd0);
        bus.done = 1'b0;

        hold_btn(0, 10);
        chk("run2", 8'(bus.state), 8'd1);
        bus.done = 1'b1;
        tick(1);
        chk("done_state", 8'(bus.state), 8'd3);
        chk("beep1", 8'(bus.beep), 8'd1);
        chk("done_on", 8'(bus.on), 8'd0);
        bus.done = 1'b0;
        tick(7);
        chk("beep8", 8'(bus.beep), 8'd1);
        tick(1);
        chk("beep_off", 8'(bus.beep), 8'd0);
        chk("still_done", 8'(bus.state), 8'd3);
        hold_btn(0, 10);
        chk("done_to_idle", 8'(bus.state), 8'd0);

        hold_btn(1, 10);
        chk("prog_pre_rst", 8'(bus.prog), 8'd1);
        hold_btn(0, 10);
        bus.done = 1'b1;
        tick(3);
        chk("beep_mid", 8'(bus.beep), 8'd1);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        bus.done = 1'b0;
        chk("rst2_state", 8'(bus.state), 8'd0);
        chk("rst2_prog", 8'(bus.prog), 8'd0);
        chk("rst2_preset", preset(), 8'h30);
        chk("rst2_beep", 8'(bus.beep), 8'd0);
        chk("rst2_on", 8'(bus.on), 8'd0);

        bus.btn_prog = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(20);
        chk("held_rst", 8'(bus.prog), 8'd0);
        bus.btn_prog = 1'b0;
        tick(10);
        hold_btn(1, 10);
        chk("repress", 8'(bus.prog), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
